// File: rtl/ysyx_24080006_rd_arbiter.sv
// AXI read-channel arbiter: IFU/LSU masters share one outstanding read,
// routed by address to either the CLINT or the external SoC master port.

package ysyx_24080006_axi_pkg;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  arid;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [1:0]  rresp;
        logic [63:0] rdata;
        logic        rlast;
        logic [3:0]  rid;
    } axi_r_s2m_t;

endpackage

module ysyx_24080006_rd_arbiter
    import ysyx_24080006_axi_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
    input  logic       clock,
    input  logic       reset,
    input  axi_r_m2s_t ifu_r_m2s,
    output axi_r_s2m_t ifu_r_s2m,
    input  axi_r_m2s_t lsu_r_m2s,
    output axi_r_s2m_t lsu_r_s2m,
    output axi_r_m2s_t clint_r_m2s,
    input  axi_r_s2m_t clint_r_s2m,
    output axi_r_m2s_t core_r_m2s,
    input  axi_r_s2m_t core_r_s2m
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R
    } state_t;

    typedef enum logic {
        M_IFU,
        M_LSU
    } master_t;

    typedef enum logic {
        T_CLINT,
        T_CORE
    } target_t;

    state_t  state,      state_nxt;
    master_t grant,      grant_nxt;
    master_t last_grant, last_grant_nxt;
    target_t target,     target_nxt;
    master_t pick;

    axi_r_m2s_t sel_m2s;
    axi_r_s2m_t sel_s2m;
    logic       ar_phase;
    logic       r_phase;

    function automatic target_t decode(input logic [31:0] addr);
        return ((addr & CLINT_MASK) == CLINT_BASE) ? T_CLINT : T_CORE;
    endfunction

    // Payload muxes hang off the registered selects only, so the AR fields
    // and R beats never depend on the arbitration decision being made.
    assign sel_m2s = (grant == M_LSU) ? lsu_r_m2s : ifu_r_m2s;
    assign sel_s2m = (target == T_CLINT) ? clint_r_s2m : core_r_s2m;

    // Round-robin only matters on a tie; last_grant starts at IFU so LSU wins first.
    always_comb begin
        pick = M_IFU;
        if (ifu_r_m2s.arvalid && lsu_r_m2s.arvalid) begin
            pick = (last_grant == M_IFU) ? M_LSU : M_IFU;
        end else if (lsu_r_m2s.arvalid) begin
            pick = M_LSU;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values computed by the combinational logic.
        if (reset) begin
            state      <= S_IDLE;
            grant      <= M_IFU;
            target     <= T_CORE;
            last_grant <= M_IFU;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            target     <= target_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt      = state;
        grant_nxt      = grant;
        target_nxt     = target;
        last_grant_nxt = last_grant;
        ar_phase       = 1'b0;
        r_phase        = 1'b0;

        case (state)
            S_IDLE: begin
                if (ifu_r_m2s.arvalid || lsu_r_m2s.arvalid) begin
                    grant_nxt  = pick;
                    target_nxt = decode((pick == M_LSU) ? lsu_r_m2s.araddr
                                                        : ifu_r_m2s.araddr);
                    state_nxt  = S_AR;
                end
            end
            S_AR: begin
                ar_phase = 1'b1;
                if (sel_m2s.arvalid && sel_s2m.arready) begin
                    state_nxt      = S_R;
                    last_grant_nxt = grant;
                end
            end
            S_R: begin
                r_phase = 1'b1;
                if (sel_s2m.rvalid && sel_m2s.rready && sel_s2m.rlast) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Downstream requests: shared payload, handshakes gated to the selected target.
    always_comb begin
        clint_r_m2s         = sel_m2s;
        core_r_m2s          = sel_m2s;
        clint_r_m2s.arvalid = ar_phase && (target == T_CLINT) && sel_m2s.arvalid;
        clint_r_m2s.rready  = r_phase  && (target == T_CLINT) && sel_m2s.rready;
        core_r_m2s.arvalid  = ar_phase && (target == T_CORE)  && sel_m2s.arvalid;
        core_r_m2s.rready   = r_phase  && (target == T_CORE)  && sel_m2s.rready;
    end

    // Upstream responses: shared payload, handshakes gated to the granted master.
    always_comb begin
        ifu_r_s2m         = sel_s2m;
        lsu_r_s2m         = sel_s2m;
        ifu_r_s2m.arready = ar_phase && (grant == M_IFU) && sel_s2m.arready;
        ifu_r_s2m.rvalid  = r_phase  && (grant == M_IFU) && sel_s2m.rvalid;
        ifu_r_s2m.rlast   = r_phase  && (grant == M_IFU) && sel_s2m.rlast;
        lsu_r_s2m.arready = ar_phase && (grant == M_LSU) && sel_s2m.arready;
        lsu_r_s2m.rvalid  = r_phase  && (grant == M_LSU) && sel_s2m.rvalid;
        lsu_r_s2m.rlast   = r_phase  && (grant == M_LSU) && sel_s2m.rlast;
    end

endmodule

// File: tb/tb_ysyx_24080006_rd_arbiter.sv
// Bench for the read arbiter: an ownership model checked every cycle plus
// directed scenarios with hand-computed expectations.

module tb_ysyx_24080006_rd_arbiter;
    import ysyx_24080006_axi_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    axi_r_m2s_t ifu_req, lsu_req, clint_req, core_req;
    axi_r_s2m_t ifu_rsp, lsu_rsp, clint_rsp, core_rsp;

    int tests = 0;
    int fails = 0;

    ysyx_24080006_rd_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .ifu_r_m2s   (ifu_req),
        .ifu_r_s2m   (ifu_rsp),
        .lsu_r_m2s   (lsu_req),
        .lsu_r_s2m   (lsu_rsp),
        .clint_r_m2s (clint_req),
        .clint_r_s2m (clint_rsp),
        .core_r_m2s  (core_req),
        .core_r_s2m  (core_rsp)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Ownership model: who holds the single read slot (-1 = nobody), whether
    // its address was accepted, where it routes, and who was served last.
    int   m_own = -1, m_last = 0, m_route = 1;
    logic m_acc = 1'b0, m_on = 1'b0;
    int   n_own, n_last, n_route;
    logic n_acc;
    axi_r_m2s_t mq;
    axi_r_s2m_t ts;

    function automatic int route_of(input logic [31:0] a);
        return ((a & 32'hFFFF_0000) == 32'h0200_0000) ? 0 : 1;
    endfunction

    always_comb begin
        mq      = (m_own == 1) ? lsu_req : ifu_req;
        ts      = (m_route == 0) ? clint_rsp : core_rsp;
        n_own   = m_own;
        n_acc   = m_acc;
        n_last  = m_last;
        n_route = m_route;
        if (m_own < 0) begin
            if (ifu_req.arvalid || lsu_req.arvalid) begin
                if (ifu_req.arvalid && lsu_req.arvalid) n_own = 1 - m_last;
                else n_own = lsu_req.arvalid ? 1 : 0;
                n_route = route_of((n_own == 1) ? lsu_req.araddr : ifu_req.araddr);
                n_acc   = 1'b0;
            end
        end else if (!m_acc) begin
            if (mq.arvalid && ts.arready) begin
                n_acc  = 1'b1;
                n_last = m_own;
            end
        end else if (ts.rvalid && mq.rready && ts.rlast) begin
            n_own = -1;
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            m_own   <= -1;
            m_acc   <= 1'b0;
            m_last  <= 0;
            m_route <= 1;
            m_on    <= 1'b1;
        end else begin
            m_own   <= n_own;
            m_acc   <= n_acc;
            m_last  <= n_last;
            m_route <= n_route;
        end
    end

    logic        ar_ph, r_ph, exp_ar_any, exp_r_any;
    logic [9:0]  exp_hs, act_hs;
    logic [48:0] exp_ar_pay, act_ar_pay;
    logic [69:0] exp_r_pay, act_r_pay;

    assign act_hs = {ifu_rsp.arready, ifu_rsp.rvalid, ifu_rsp.rlast,
                     lsu_rsp.arready, lsu_rsp.rvalid, lsu_rsp.rlast,
                     clint_req.arvalid, clint_req.rready,
                     core_req.arvalid, core_req.rready};

    always_comb begin
        ar_ph  = (m_own >= 0) && !m_acc;
        r_ph   = (m_own >= 0) && m_acc;
        exp_hs = {ar_ph && (m_own == 0) && ts.arready,
                  r_ph  && (m_own == 0) && ts.rvalid,
                  r_ph  && (m_own == 0) && ts.rlast,
                  ar_ph && (m_own == 1) && ts.arready,
                  r_ph  && (m_own == 1) && ts.rvalid,
                  r_ph  && (m_own == 1) && ts.rlast,
                  ar_ph && (m_route == 0) && mq.arvalid,
                  r_ph  && (m_route == 0) && mq.rready,
                  ar_ph && (m_route == 1) && mq.arvalid,
                  r_ph  && (m_route == 1) && mq.rready};
        exp_ar_any = ar_ph && mq.arvalid;
        exp_r_any  = r_ph && ts.rvalid;
        exp_ar_pay = {mq.araddr, mq.arid, mq.arlen, mq.arsize, mq.arburst};
        act_ar_pay = (m_route == 0)
            ? {clint_req.araddr, clint_req.arid, clint_req.arlen, clint_req.arsize, clint_req.arburst}
            : {core_req.araddr, core_req.arid, core_req.arlen, core_req.arsize, core_req.arburst};
        exp_r_pay  = {ts.rdata, ts.rresp, ts.rid};
        act_r_pay  = (m_own == 1) ? {lsu_rsp.rdata, lsu_rsp.rresp, lsu_rsp.rid}
                                  : {ifu_rsp.rdata, ifu_rsp.rresp, ifu_rsp.rid};
    end

    always @(negedge clock) begin
        if (m_on && !reset) begin
            check("cyc_handshake", 80'(act_hs), 80'(exp_hs));
            if (exp_ar_any) check("cyc_ar_payload", 80'(act_ar_pay), 80'(exp_ar_pay));
            if (exp_r_any)  check("cyc_r_payload", 80'(act_r_pay), 80'(exp_r_pay));
        end
    end

    logic [63:0] ifu_beats[$];
    always @(negedge clock) begin
        if (ifu_rsp.rvalid && ifu_req.rready) ifu_beats.push_back(ifu_rsp.rdata);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] burst_data [4];
    int          burst_idx  [6];
    logic        burst_rdy  [6];

    initial begin
        burst_data = '{64'h1111_0000, 64'h2222_0001, 64'h3333_0002, 64'h4444_0003};
        burst_idx  = '{0, 1, 2, 2, 2, 3};
        burst_rdy  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        ifu_req   = '0;
        lsu_req   = '0;
        clint_rsp = '0;
        core_rsp  = '0;
        ifu_req.rready    = 1'b1;
        lsu_req.rready    = 1'b1;
        clint_rsp.arready = 1'b1;
        core_rsp.arready  = 1'b1;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1 check("reset_outputs_quiet", 80'(act_hs), 80'(0));

        // Simultaneous requests out of reset: LSU wins the tie.
        ifu_req.arvalid = 1'b1; ifu_req.araddr = 32'h3000_0000; ifu_req.arid = 4'd1;
        lsu_req.arvalid = 1'b1; lsu_req.araddr = 32'h3000_1000; lsu_req.arid = 4'd2;
        #1 check("tie_idle_no_arready", 80'({ifu_rsp.arready, lsu_rsp.arready}), 80'(0));
        step();
        #1 check("tie_lsu_arvalid", 80'(core_req.arvalid), 80'(1));
        check("tie_lsu_addr", 80'(core_req.araddr), 80'(32'h3000_1000));
        check("tie_ifu_held", 80'(ifu_rsp.arready), 80'(0));
        step();
        lsu_req.arvalid = 1'b0;
        core_rsp.rvalid = 1'b1; core_rsp.rdata = 64'hAAAA_5555; core_rsp.rlast = 1'b1; core_rsp.rid = 4'd2;
        #1 check("tie_lsu_beat", 80'(lsu_rsp.rdata), 80'(64'hAAAA_5555));
        check("tie_ifu_no_rvalid", 80'(ifu_rsp.rvalid), 80'(0));
        step();
        core_rsp.rvalid = 1'b0; core_rsp.rlast = 1'b0;
        #1 check("tie_m1_no_arvalid", 80'(core_req.arvalid), 80'(0));
        step();
        #1 check("tie_ifu_arvalid_m2", 80'(core_req.arvalid), 80'(1));
        check("tie_ifu_addr", 80'(core_req.araddr), 80'(32'h3000_0000));
        step();
        ifu_req.arvalid = 1'b0;
        core_rsp.rvalid = 1'b1; core_rsp.rdata = 64'h0000_0413; core_rsp.rlast = 1'b1; core_rsp.rid = 4'd1;
        #1 check("ifu_single_beat", 80'(ifu_rsp.rdata), 80'(64'h0000_0413));
        check("ifu_single_lsu_quiet", 80'(lsu_rsp.rvalid), 80'(0));
        step();
        core_rsp.rvalid = 1'b0; core_rsp.rlast = 1'b0;

        // IFU 4-beat INCR burst with a 2-cycle rready stall; LSU asks while busy.
        ifu_req.arvalid = 1'b1; ifu_req.araddr = 32'h3000_0100; ifu_req.arid = 4'd3;
        ifu_req.arlen = 8'd3; ifu_req.arsize = 3'b011; ifu_req.arburst = 2'b01;
        step();
        #1 check("burst_arlen", 80'(core_req.arlen), 80'(3));
        step();
        ifu_req.arvalid = 1'b0; ifu_req.arlen = 8'd0;
        lsu_req.arvalid = 1'b1; lsu_req.araddr = 32'h3000_2000; lsu_req.arid = 4'd4;
        ifu_beats.delete();
        for (int k = 0; k < 6; k++) begin
            core_rsp.rvalid = 1'b1;
            core_rsp.rdata  = burst_data[burst_idx[k]];
            core_rsp.rlast  = (burst_idx[k] == 3);
            core_rsp.rid    = 4'd3;
            ifu_req.rready  = burst_rdy[k];
            #1 check("burst_lsu_held", 80'(lsu_rsp.arready), 80'(0));
            if (k == 3) check("burst_stall_rready", 80'(core_req.rready), 80'(0));
            if (k == 4) check("burst_no_early_rlast", 80'(ifu_rsp.rlast), 80'(0));
            step();
        end
        core_rsp.rvalid = 1'b0; core_rsp.rlast = 1'b0; ifu_req.rready = 1'b1;
        check("burst_beat_count", 80'(ifu_beats.size()), 80'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < ifu_beats.size()) check("burst_beat_data", 80'(ifu_beats[i]), 80'(burst_data[i]));
        end
        #1 check("burst_done_idle", 80'(ifu_rsp.rvalid), 80'(0));

        // Pending LSU read gets an error response, passed through untouched.
        step();
        #1 check("err_lsu_arvalid", 80'(core_req.arvalid), 80'(1));
        check("err_lsu_addr", 80'(core_req.araddr), 80'(32'h3000_2000));
        step();
        lsu_req.arvalid = 1'b0;
        core_rsp.rvalid = 1'b1; core_rsp.rdata = 64'hDEAD_BEEF; core_rsp.rresp = 2'b10;
        core_rsp.rlast = 1'b1; core_rsp.rid = 4'd4;
        #1 check("err_rresp", 80'(lsu_rsp.rresp), 80'(2'b10));
        step();
        core_rsp.rvalid = 1'b0; core_rsp.rlast = 1'b0; core_rsp.rresp = 2'b00;

        // IFU alone after the error completes normally.
        ifu_req.arvalid = 1'b1; ifu_req.araddr = 32'h3000_0000; ifu_req.arid = 4'd5;
        #1 check("ifu_n_no_arvalid", 80'(core_req.arvalid), 80'(0));
        step();
        #1 check("ifu_n1_arvalid", 80'(core_req.arvalid), 80'(1));
        step();
        ifu_req.arvalid = 1'b0;
        core_rsp.rvalid = 1'b1; core_rsp.rdata = 64'h0000_0413; core_rsp.rlast = 1'b1; core_rsp.rid = 4'd5;
        #1 check("ifu_after_err_data", 80'(ifu_rsp.rdata), 80'(64'h0000_0413));
        check("ifu_after_err_rresp", 80'(ifu_rsp.rresp), 80'(0));
        step();
        core_rsp.rvalid = 1'b0; core_rsp.rlast = 1'b0;

        // LSU to the CLINT window.
        lsu_req.arvalid = 1'b1; lsu_req.araddr = 32'h0200_BFF8; lsu_req.arid = 4'd6;
        step();
        #1 check("clint_arvalid", 80'(clint_req.arvalid), 80'(1));
        check("clint_core_quiet", 80'(core_req.arvalid), 80'(0));
        check("clint_addr", 80'(clint_req.araddr), 80'(32'h0200_BFF8));
        step();
        lsu_req.arvalid = 1'b0;
        clint_rsp.rvalid = 1'b1; clint_rsp.rdata = 64'h1234_5678; clint_rsp.rlast = 1'b1; clint_rsp.rid = 4'd6;
        #1 check("clint_data", 80'(lsu_rsp.rdata), 80'(64'h1234_5678));
        check("clint_ifu_quiet", 80'(ifu_rsp.rvalid), 80'(0));
        step();
        clint_rsp.rvalid = 1'b0; clint_rsp.rlast = 1'b0;

        // Reset pulsed mid-burst abandons the transaction.
        ifu_req.arvalid = 1'b1; ifu_req.araddr = 32'h3000_0040; ifu_req.arlen = 8'd1; ifu_req.arid = 4'd7;
        step();
        step();
        ifu_req.arvalid = 1'b0; ifu_req.arlen = 8'd0;
        core_rsp.rvalid = 1'b1; core_rsp.rdata = 64'h5A5A_0001; core_rsp.rlast = 1'b0; core_rsp.rid = 4'd7;
        #1 check("rst_mid_rvalid", 80'(ifu_rsp.rvalid), 80'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1 check("rst_mid_quiet", 80'(act_hs), 80'(0));
        core_rsp.rvalid = 1'b0;
        ifu_req.arvalid = 1'b1; ifu_req.araddr = 32'h3000_0080; ifu_req.arid = 4'd8;
        step();
        #1 check("rst_fresh_arvalid", 80'(core_req.arvalid), 80'(1));
        step();
        ifu_req.arvalid = 1'b0;
        core_rsp.rvalid = 1'b1; core_rsp.rdata = 64'hC0DE_0008; core_rsp.rlast = 1'b1; core_rsp.rid = 4'd8;
        #1 check("rst_fresh_data", 80'(ifu_rsp.rdata), 80'(64'hC0DE_0008));
        step();
        core_rsp.rvalid = 1'b0; core_rsp.rlast = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
